ma_stbuf: RTL
=============

MA_STBUF -- requirements
Module: ma_stbuf

Interface
REQ-001 Parameter DWIDTH, default 11, RAM word-address width; RAM word address is adr[DWIDTH+1:2].
REQ-002 Parameter SB_DEPTH, default 4, store-buffer entries; power of two, 2..16.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_ld_ma / cmd_st_ma  in  1 each  load / store valid in MA.
REQ-006 adr_ma  in  32  effective byte address.
REQ-007 st_data_ma  in  32  store source data, right-justified.
REQ-008 ldst_code_ma  in  3  000 byte, 001 half, 010 word; other codes: no RAM or IO effect.
REQ-009 rst_pipe_ma  in  1  squash the current MA command; buffered entries survive.
REQ-010 ram_wr_block  in  1  external refill owns the RAM write port this cycle.
REQ-011 drain_req  in  1  fence: drain the buffer, accept no new stores.
REQ-012 ram_radr / ram_wadr  out  DWIDTH each  RAM read / write word address.
REQ-013 ram_rdata  in  32  RAM read data, one cycle after ram_radr.
REQ-014 ram_wdata  out  32 and ram_wen  out  4  RAM write data and byte enables.
REQ-015 io_we  out  1, io_adr  out  14 (adr[15:2]), io_wdata  out  32  IO-region word write.
REQ-016 ld_data_wb  out  32  WB load word: RAM data with forwarded bytes merged.
REQ-017 stall_sb  out  1  pipeline must hold the MA command.
REQ-018 sb_empty  out  1  no valid entries.

Function
REQ-019 IO region is adr_ma[31:30]==2'b11; all other addresses are RAM.
REQ-020 Store alignment: byte on lane adr[1:0]; half on lanes {1,0} or {3,2} by adr[1]; word on all lanes; be derived identically.
REQ-021 Entry = {word adr, 32-bit data, 4-bit be}; circular FIFO, rd_ptr/wr_ptr wrap modulo SB_DEPTH; count 0..SB_DEPTH.
REQ-022 Push: a RAM store with no stall_sb and no rst_pipe_ma is accepted at the clock edge.
REQ-023 Combine: if the youngest valid entry has the same word address and is not popping this cycle, merge the new bytes in (new bytes win, be OR-ed); count unchanged.
REQ-024 Pop: when count>0 and ram_wr_block=0, the oldest entry drives ram_wadr/ram_wdata/ram_wen this cycle; otherwise ram_wen=0.
REQ-025 Full with simultaneous pop: the store is accepted (no stall).
REQ-026 stall_sb = cmd_st_ma & RAM region & full & no pop, OR IO access & ~sb_empty, OR cmd_st_ma & drain_req.
REQ-027 IO store with sb_empty: io_we=1 combinationally for one cycle, with io_wdata = aligned data; nothing is buffered.
REQ-028 Load: ram_radr=adr_ma[DWIDTH+1:2] combinationally; all valid entries, including one popping, are compared per byte, with the youngest match winning.
REQ-029 Forward mask and bytes are registered MA->WB; ld_data_wb byte i = forwarded byte if mask[i], else ram_rdata byte i; latency one cycle, with no stall for any overlap.
REQ-030 An IO load produces mask 0 and performs no forwarding.
REQ-031 A load squashed by rst_pipe_ma clears the registered mask.
REQ-032 sb_empty = (count==0), registered state.

Reset
REQ-033 On rst_n low, immediately: count=0, pointers=0, all be=0, forward mask=0.
REQ-034 During reset, outputs are: ram_wen=0, io_we=0, stall_sb=0, sb_empty=1, ld_data_wb equals ram_rdata.
REQ-035 A reset asserted mid-drain discards all entries; no partial write is retried.

Structure
REQ-036 Shared package ma_pkg holds the ldst code constants, IO region constant 2'b11, and the entry struct.
REQ-037 One sub-module, ma_st_align: combinational data/byte-enable aligner, instantiated once for stores.

Verification
REQ-038 sb 0x100 data 0xAB, then lw 0x100 with RAM 0x11223344 -> ld_data_wb=0x112233AB the next cycle.
REQ-039 sh 0x202=0xBEEF, then sb 0x200=0x01 back-to-back with ram_wr_block=1 -> one entry, be=1101, data 0xBEEF??01; drains as one write.
REQ-040 ram_wr_block=1, 5 word stores at distinct addresses (depth 4) -> 5th store holds stall_sb=1 until the block releases; 4 writes follow in FIFO order.
REQ-041 IO sw 0xC0000010 with 2 entries pending -> stall_sb for 2 cycles, then io_we=1, io_adr=0x0004.
REQ-042 Full buffer plus store while popping -> no stall; count stays 4; wrap of wr_ptr 3->0 verified.
REQ-043 Assert rst_n low with 3 entries -> sb_empty=1 at once; no further ram_wen.

Source files
------------

// File: rtl/ma_pkg.sv
// Memory-access stage shared types: ldst codes, IO region tag,
// store-buffer entry layout and a byte-enable expansion helper.
package ma_pkg;

  localparam logic [2:0] LDST_B = 3'b000;
  localparam logic [2:0] LDST_H = 3'b001;
  localparam logic [2:0] LDST_W = 3'b010;

  localparam logic [1:0] IO_REGION = 2'b11;

  // Word address field is sized for the widest RAM;
  // narrower RAMs zero-extend into it.
  localparam int SB_AW = 30;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [31:0]      data;
    logic [3:0]       be;
  } sb_entry_t;

  function automatic logic [31:0] be2mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/ma_st_align.sv
// Store aligner: replicates right-justified data onto byte lanes
// and builds byte enables. Ports: adr_i, code_i, data_i -> data_o, be_o.
module ma_st_align
  import ma_pkg::*;
(
  input  logic [1:0]  adr_i,
  input  logic [2:0]  code_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o
);

  logic is_b;
  logic is_h;
  logic is_w;

  assign is_b = (code_i == LDST_B);
  assign is_h = (code_i == LDST_H);
  assign is_w = (code_i == LDST_W);

  // Unsupported codes leave be_o at zero, which the
  // caller treats as "no memory effect".
  always_comb begin
    data_o = '0;
    be_o   = '0;
    unique case (1'b1)
      is_b: begin
        data_o = {4{data_i[7:0]}};
        be_o   = 4'b0001 << adr_i;
      end
      is_h: begin
        data_o = {2{data_i[15:0]}};
        be_o   = adr_i[1] ? 4'b1100 : 4'b0011;
      end
      is_w: begin
        data_o = data_i;
        be_o   = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ma_stbuf.sv
// MA-stage store buffer with store combining, byte forwarding to
// loads and in-order IO. Ports: MA command in, RAM/IO ports out.
module ma_stbuf
  import ma_pkg::*;
#(
  parameter int DWIDTH   = 11,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_ld_ma,
  input  logic              cmd_st_ma,
  input  logic [31:0]       adr_ma,
  input  logic [31:0]       st_data_ma,
  input  logic [2:0]        ldst_code_ma,
  input  logic              rst_pipe_ma,
  input  logic              ram_wr_block,
  input  logic              drain_req,
  output logic [DWIDTH-1:0] ram_radr,
  output logic [DWIDTH-1:0] ram_wadr,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wen,
  output logic              io_we,
  output logic [13:0]       io_adr,
  output logic [31:0]       io_wdata,
  output logic [31:0]       ld_data_wb,
  output logic              stall_sb,
  output logic              sb_empty
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t       ent_q [SB_DEPTH];
  sb_entry_t       ent_d [SB_DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      fmask_q, fmask_d;
  logic [31:0]     fdata_q, fdata_d;

  logic [31:0]     al_data;
  logic [3:0]      al_be;
  logic            code_ok;
  logic            is_io;
  logic            io_acc;
  logic            st_ram;
  logic            full;
  logic            pop;
  logic            push;
  logic            comb;
  logic [PW-1:0]   yng;
  logic [SB_AW-1:0] madr;
  logic [3:0]      fmask;
  logic [31:0]     fdata;
  logic [PW-1:0]   idx;
  logic [31:0]     wmask;
  logic            unused_adr;

  ma_st_align u_align (
    .adr_i  (adr_ma[1:0]),
    .code_i (ldst_code_ma),
    .data_i (st_data_ma),
    .data_o (al_data),
    .be_o   (al_be)
  );

  assign unused_adr = ^adr_ma;

  assign code_ok = |al_be;
  assign is_io   = (adr_ma[31:30] == IO_REGION);
  assign io_acc  = (cmd_ld_ma | cmd_st_ma) & is_io;
  assign st_ram  = cmd_st_ma & ~is_io & code_ok;
  assign madr    = SB_AW'(adr_ma[DWIDTH+1:2]);

  assign sb_empty = (cnt_q == '0);
  assign full     = (cnt_q == CW'(SB_DEPTH));
  assign pop      = ~sb_empty & ~ram_wr_block;

  // A full buffer still takes a store when the head
  // drains in the same cycle.
  assign stall_sb = (cmd_st_ma & ~is_io & full & ~pop)
                  | (io_acc & ~sb_empty)
                  | (cmd_st_ma & drain_req);

  assign push = st_ram & ~stall_sb & ~rst_pipe_ma;
  assign yng  = wr_q - PW'(1);

  // Never merge into an entry that is leaving this cycle:
  // the bytes would be lost with it.
  assign comb = push & ~sb_empty
              & (ent_q[yng].adr == madr)
              & ~(pop & (cnt_q == CW'(1)));

  assign wmask = be2mask(al_be);

  always_comb begin
    ent_d = ent_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    if (comb) begin
      ent_d[yng].data = (ent_q[yng].data & ~wmask)
                      | (al_data & wmask);
      ent_d[yng].be   = ent_q[yng].be | al_be;
    end else if (push) begin
      ent_d[wr_q].adr  = madr;
      ent_d[wr_q].data = al_data;
      ent_d[wr_q].be   = al_be;
      wr_d = wr_q + PW'(1);
    end
    cnt_d = cnt_q
          + CW'(push & ~comb)
          - CW'(pop);
  end

  // Walk oldest to youngest so later stores overwrite
  // earlier ones byte by byte.
  always_comb begin
    fmask = '0;
    fdata = '0;
    idx   = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = rd_q + PW'(k);
      if ((CW'(k) < cnt_q) &&
          (ent_q[idx].adr == madr)) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_q[idx].be[b]) begin
            fmask[b]        = 1'b1;
            fdata[8*b +: 8] = ent_q[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    fmask_d = '0;
    fdata_d = '0;
    if (cmd_ld_ma & ~is_io & ~rst_pipe_ma) begin
      fmask_d = fmask;
      fdata_d = fdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      fmask_q <= '0;
      fdata_q <= '0;
    end else begin
      ent_q   <= ent_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      fmask_q <= fmask_d;
      fdata_q <= fdata_d;
    end
  end

  assign ram_radr  = adr_ma[DWIDTH+1:2];
  assign ram_wadr  = ent_q[rd_q].adr[DWIDTH-1:0];
  assign ram_wdata = ent_q[rd_q].data;
  assign ram_wen   = pop ? ent_q[rd_q].be : 4'b0000;

  assign io_we    = cmd_st_ma & is_io & code_ok
                  & ~stall_sb & ~rst_pipe_ma;
  assign io_adr   = adr_ma[15:2];
  assign io_wdata = al_data;

  assign ld_data_wb = (fdata_q & be2mask(fmask_q))
                    | (ram_rdata & ~be2mask(fmask_q));

endmodule
